// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller producing per-stage flush/stall (ports: clk, reset, d_rs, d_rt, e_rt, e_mem_to_reg, e_branch_taken, f_req, i_data_ok, m_req, d_data_ok -> hazard, stall_cycles when HAZARD_PERF_CNT_EN is defined)
package hazard_ctrl_pkg;
  typedef logic [4:0] creg_addr_t;
  typedef struct packed {
    logic flush;
    logic stall;
  } stage_ctl_t;
  typedef struct packed {
    stage_ctl_t fetch;
    stage_ctl_t decode;
    stage_ctl_t execute;
    stage_ctl_t memory;
  } hazard_data_t;
endpackage

module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  creg_addr_t   d_rs,
  input  creg_addr_t   d_rt,
  input  creg_addr_t   e_rt,
  input  logic         e_mem_to_reg,
  input  logic         e_branch_taken,
  input  logic         f_req,
  input  logic         i_data_ok,
  input  logic         m_req,
  input  logic         d_data_ok,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0]  stall_cycles,
`endif
  output hazard_data_t hazard
);
  typedef enum logic [1:0] {INIT, RUN, DROP} state_t;
  state_t state, state_nxt;
  logic dmem_wait, imem_wait, load_use;
  assign dmem_wait = m_req && !d_data_ok;
  assign imem_wait = f_req && !i_data_ok;
  assign load_use  = e_mem_to_reg && e_rt != '0 && (e_rt == d_rs || e_rt == d_rt);
  function automatic hazard_data_t hz(input logic [3:0] f, input logic [3:0] s);
    hz = '{fetch: '{f[3], s[3]}, decode: '{f[2], s[2]}, execute: '{f[1], s[1]}, memory: '{f[0], s[0]}};
  endfunction
  always_ff @(posedge clk)
    if (reset) state <= INIT;
    else       state <= state_nxt;
  // Any encoding other than RUN/DROP behaves as INIT so the FSM always recovers.
  always_comb begin
    state_nxt = state;
    hazard    = hz(4'b0000, 4'b0000);
    if (reset || (state != RUN && state != DROP)) begin
      hazard    = hz(4'b1111, 4'b0000);
      state_nxt = RUN;
    end else if (dmem_wait) begin
      hazard    = hz(4'b0000, 4'b1111);
      state_nxt = (state == DROP && i_data_ok) ? RUN : state;
    end else if (state == DROP) begin
      hazard    = hz(4'b0100, 4'b1000);
      state_nxt = i_data_ok ? RUN : DROP;
    end else if (e_branch_taken) begin
      hazard    = hz(4'b0110, 4'b0000);
      state_nxt = imem_wait ? DROP : RUN;
    end else if (imem_wait) begin
      hazard    = hz(4'b0100, 4'b1000);
    end else if (load_use) begin
      hazard    = hz(4'b0010, 4'b1100);
    end
  end
`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk)
    if (reset) stall_cycles <= '0;
    else if (hazard.fetch.stall && stall_cycles != 32'hFFFF_FFFF) stall_cycles <= stall_cycles + 32'd1;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl with a rule-level reference model
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;
  logic clk, reset, e_mem_to_reg, e_branch_taken, f_req, i_data_ok, m_req, d_data_ok;
  creg_addr_t d_rs, d_rt, e_rt;
  hazard_data_t hazard;
  int nchk = 0, nerr = 0;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, m_cnt, base;
`endif
  hazard_ctrl dut (
    .clk(clk), .reset(reset), .d_rs(d_rs), .d_rt(d_rt), .e_rt(e_rt),
    .e_mem_to_reg(e_mem_to_reg), .e_branch_taken(e_branch_taken),
    .f_req(f_req), .i_data_ok(i_data_ok), .m_req(m_req), .d_data_ok(d_data_ok),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cycles(stall_cycles),
`endif
    .hazard(hazard)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  logic m_init = 1'b1, m_drop = 1'b0;
  function automatic logic [7:0] model_hz();
    logic lu;
    lu = e_mem_to_reg && e_rt != 0 && (e_rt == d_rs || e_rt == d_rt);
    if (reset || m_init)                 return {4'b1111, 4'b0000};
    if (m_req && !d_data_ok)             return {4'b0000, 4'b1111};
    if (m_drop)                          return {4'b0100, 4'b1000};
    if (e_branch_taken)                  return {4'b0110, 4'b0000};
    if (f_req && !i_data_ok)             return {4'b0100, 4'b1000};
    if (lu)                              return {4'b0010, 4'b1100};
    return 8'h00;
  endfunction
  function automatic logic [7:0] dut_hz();
    return {hazard.fetch.flush, hazard.decode.flush, hazard.execute.flush, hazard.memory.flush,
            hazard.fetch.stall, hazard.decode.stall, hazard.execute.stall, hazard.memory.stall};
  endfunction
  always @(posedge clk) begin
    logic [7:0] e;
    e = model_hz();
`ifdef HAZARD_PERF_CNT_EN
    if (reset) m_cnt <= 0;
    else if (e[3] && m_cnt != 32'hFFFF_FFFF) m_cnt <= m_cnt + 1;
`endif
    if (reset) begin m_init <= 1; m_drop <= 0; end
    else if (m_init) begin m_init <= 0; m_drop <= 0; end
    else if (m_drop) m_drop <= !i_data_ok;
    else m_drop <= !(m_req && !d_data_ok) && e_branch_taken && f_req && !i_data_ok;
  end
  always @(negedge clk) begin
    nchk++;
    if (dut_hz() !== model_hz()) begin
      nerr++;
      $display("FAIL model_cmp t=%0t flush/stall got %b/%b exp %b/%b", $time,
               dut_hz()[7:4], dut_hz()[3:0], model_hz()[7:4], model_hz()[3:0]);
    end
`ifdef HAZARD_PERF_CNT_EN
    nchk++;
    if (stall_cycles !== m_cnt) begin
      nerr++;
      $display("FAIL cnt_cmp t=%0t got %0d exp %0d", $time, stall_cycles, m_cnt);
    end
`endif
  end
  task automatic set(input logic rs, input logic mtr, input creg_addr_t ert, input creg_addr_t drs,
                     input creg_addr_t drt, input logic br, input logic fr, input logic iok,
                     input logic mr, input logic dok);
    reset = rs; e_mem_to_reg = mtr; e_rt = ert; d_rs = drs; d_rt = drt;
    e_branch_taken = br; f_req = fr; i_data_ok = iok; m_req = mr; d_data_ok = dok;
  endtask
  task automatic idle();
    set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic cyc(input string name, input logic [3:0] ef, input logic [3:0] es);
    @(negedge clk);
    nchk++;
    if (dut_hz() !== {ef, es}) begin
      nerr++;
      $display("FAIL %s flush/stall got %b/%b exp %b/%b", name, dut_hz()[7:4], dut_hz()[3:0], ef, es);
    end
    @(posedge clk); #1;
  endtask
  initial begin
    set(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc("reset", 4'b1111, 4'b0000);
    idle();
    cyc("init_after_reset", 4'b1111, 4'b0000);
    cyc("run_idle", 4'b0000, 4'b0000);
    set(0, 1, 5, 5, 0, 0, 0, 0, 0, 0);
    cyc("load_use_rs", 4'b0010, 4'b1100);
    set(0, 1, 7, 1, 7, 0, 0, 0, 0, 0);
    cyc("load_use_rt", 4'b0010, 4'b1100);
    set(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("load_use_r0", 4'b0000, 4'b0000);
    set(0, 0, 5, 5, 0, 0, 0, 0, 0, 0);
    cyc("no_load", 4'b0000, 4'b0000);
`ifdef HAZARD_PERF_CNT_EN
    base = stall_cycles;
`endif
    set(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) cyc("dmem_wait", 4'b0000, 4'b1111);
    set(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    cyc("dmem_ok", 4'b0000, 4'b0000);
`ifdef HAZARD_PERF_CNT_EN
    nchk++;
    if (stall_cycles - base !== 32'd4) begin
      nerr++;
      $display("FAIL dmem_cnt got %0d exp 4", stall_cycles - base);
    end
`endif
    set(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc("imem_wait", 4'b0100, 4'b1000);
    set(0, 1, 3, 3, 0, 0, 1, 0, 0, 0);
    cyc("imem_over_lu", 4'b0100, 4'b1000);
    set(0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    cyc("dmem_over_br", 4'b0000, 4'b1111);
    set(0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    cyc("redirect", 4'b0110, 4'b0000);
    set(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc("drop1", 4'b0100, 4'b1000);
    set(0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    cyc("drop_dmem", 4'b0000, 4'b1111);
    set(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    cyc("drop_ok", 4'b0100, 4'b1000);
    set(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    cyc("run_after_drop", 4'b0000, 4'b0000);
    set(0, 1, 9, 0, 9, 1, 0, 0, 0, 0);
    cyc("br_and_lu", 4'b0110, 4'b0000);
    idle();
    cyc("idle2", 4'b0000, 4'b0000);
    set(0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    cyc("redirect2", 4'b0110, 4'b0000);
    set(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc("drop2", 4'b0100, 4'b1000);
    set(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc("reset_in_drop", 4'b1111, 4'b0000);
    set(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc("init_after_drop", 4'b1111, 4'b0000);
    set(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    cyc("late_iok", 4'b0000, 4'b0000);
    idle();
    cyc("final_idle", 4'b0000, 4'b0000);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
